// File: rtl/n64adv_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : n64adv_rst_sequencer
// Brief   : Multi-channel reset sequencer. It synchronises the enables and
//           config inputs, holds each channel after a change or a soft
//           request, and releases the channels in order with a stagger.
// Rev     : 1.0 - initial release
// ============================================================================
module n64adv_rst_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int CFG_W       = 2,
  parameter int HOLD_W      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int STAGGER     = 4
) (
  input  logic                      clk,
  input  logic                      async_rst_i,
  input  logic [NUM_CH-1:0]         ch_en_i,
  input  logic [NUM_CH*CFG_W-1:0]   cfg_i,
  input  logic [NUM_CH-1:0]         force_rst_i,
  output logic [NUM_CH-1:0]         nrst_o,
  output logic [2*NUM_CH-1:0]       state_o,
  output logic                      busy_o
);

  localparam int RUN_W = (STAGGER > 0) ? $clog2(STAGGER + 1) : 1;
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(STAGGER);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = '1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HOLD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } ch_state_t;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0]       en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0][NUM_CH*CFG_W-1:0] cfg_sync_q, cfg_sync_d;
  logic [2*NUM_CH-1:0]      state_q, state_d;
  logic [NUM_CH*HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [NUM_CH-1:0]        nrst_q, nrst_d;
  logic                     busy_q, busy_d;
  logic [NUM_CH-1:0]        en_s;
  logic [NUM_CH*CFG_W-1:0]  cfg_last, cfg_prev;

  always_comb begin
    en_sync_d     = en_sync_q;
    cfg_sync_d    = cfg_sync_q;
    en_sync_d[0]  = ch_en_i;
    cfg_sync_d[0] = cfg_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      en_sync_d[k]  = en_sync_q[k-1];
      cfg_sync_d[k] = cfg_sync_q[k-1];
    end
  end

  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign cfg_last = cfg_sync_q[SYNC_STAGES-1];
  assign cfg_prev = cfg_sync_q[SYNC_STAGES-2];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t         cur, nxt;
    logic [HOLD_W-1:0] hcnt, hcnt_nxt;
    logic              cfg_chg;
    logic              prev_run;
    logic              prev_ok;

    assign cur     = ch_state_t'(state_q[2*i +: 2]);
    assign hcnt    = hold_cnt_q[i*HOLD_W +: HOLD_W];
    assign cfg_chg = (cfg_last[i*CFG_W +: CFG_W] != cfg_prev[i*CFG_W +: CFG_W]);

    if (i == 0) begin : g_first
      assign prev_run = 1'b1;
      assign prev_ok  = 1'b1;
    end else begin : g_chain
      // Tracks how long the upstream channel has been in RUN; it only
      // exists where a downstream channel consumes it.
      logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
      logic             up_run;

      assign up_run = (state_q[2*(i-1) +: 2] == ST_RUN);

      always_comb begin
        run_cnt_d = '0;
        if (up_run) begin
          run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RUN_W'(1);
        end
      end

      always_ff @(posedge clk or posedge async_rst_i) begin
        if (async_rst_i) begin
          run_cnt_q <= '0;
        end else begin
          run_cnt_q <= run_cnt_d;
        end
      end

      assign prev_run = up_run;
      assign prev_ok  = up_run && (run_cnt_q == RUN_MAX);
    end

    always_comb begin
      nxt      = cur;
      hcnt_nxt = hcnt;
      if (!en_s[i]) begin
        nxt      = ST_OFF;
        hcnt_nxt = '0;
      end else if (cfg_chg || force_rst_i[i]) begin
        nxt      = ST_HOLD;
        hcnt_nxt = HOLD_LOAD;
      end else begin
        case (cur)
          ST_OFF: begin
            nxt      = ST_HOLD;
            hcnt_nxt = HOLD_LOAD;
          end
          ST_HOLD: begin
            if (hcnt != '0) begin
              hcnt_nxt = hcnt - HOLD_W'(1);
            end else begin
              nxt = (i == 0) ? ST_RUN : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (prev_ok) begin
              nxt = ST_RUN;
            end
          end
          ST_RUN: begin
            // Cascade: lose the upstream channel, fall back to waiting.
            if (!prev_run) begin
              nxt = ST_WAIT;
            end
          end
          default: nxt = ST_OFF;
        endcase
      end
    end

    assign state_d[2*i +: 2]             = nxt;
    assign hold_cnt_d[i*HOLD_W +: HOLD_W] = hcnt_nxt;
    assign nrst_d[i]                     = (nxt == ST_RUN);
  end

  assign busy_d = ~(&nrst_d);

  always_ff @(posedge clk or posedge async_rst_i) begin
    if (async_rst_i) begin
      en_sync_q  <= '0;
      cfg_sync_q <= '0;
      state_q    <= '0;
      hold_cnt_q <= '0;
      nrst_q     <= '0;
      busy_q     <= 1'b1;
    end else begin
      en_sync_q  <= en_sync_d;
      cfg_sync_q <= cfg_sync_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      nrst_q     <= nrst_d;
      busy_q     <= busy_d;
    end
  end

  assign nrst_o  = nrst_q;
  assign state_o = state_q;
  assign busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_n64adv_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_n64adv_rst_sequencer
// Brief   : Directed bench for the reset sequencer with an edge-indexed
//           scoreboard; also covers a single-channel, zero-stagger instance.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_n64adv_rst_sequencer;

  logic       clk = 1'b0;
  logic       async_rst_i = 1'b0;
  logic [2:0] ch_en_i = 3'b000;
  logic [5:0] cfg_i = 6'b000000;
  logic [2:0] force_rst_i = 3'b000;
  logic [2:0] nrst_o;
  logic [5:0] state_o;
  logic       busy_o;

  logic       ch_en_b = 1'b0;
  logic [1:0] cfg_b = 2'b00;
  logic       force_b = 1'b0;
  logic       nrst_b;
  logic [1:0] state_b;
  logic       busy_b;

  always #5 clk = ~clk;

  n64adv_rst_sequencer dut (
    .clk         (clk),
    .async_rst_i (async_rst_i),
    .ch_en_i     (ch_en_i),
    .cfg_i       (cfg_i),
    .force_rst_i (force_rst_i),
    .nrst_o      (nrst_o),
    .state_o     (state_o),
    .busy_o      (busy_o)
  );

  n64adv_rst_sequencer #(
    .NUM_CH  (1),
    .HOLD_W  (1),
    .STAGGER (0)
  ) dut_small (
    .clk         (clk),
    .async_rst_i (async_rst_i),
    .ch_en_i     (ch_en_b),
    .cfg_i       (cfg_b),
    .force_rst_i (force_b),
    .nrst_o      (nrst_b),
    .state_o     (state_b),
    .busy_o      (busy_b)
  );

  localparam int K_NRST  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_STATE = 2;
  localparam int K_NRSTB = 3;

  typedef struct {
    int         e;
    int         kind;
    logic [5:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   base = 0;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] observe(input int kind);
    case (kind)
      K_NRST:  return {3'b000, nrst_o};
      K_BUSY:  return {5'b00000, busy_o};
      K_STATE: return state_o;
      default: return {5'b00000, nrst_b};
    endcase
  endfunction

  task automatic push(input int e, input int kind, input logic [5:0] v, input string tag);
    exp_t it;
    it.e    = e;
    it.kind = kind;
    it.val  = v;
    it.tag  = $sformatf("%s@%0d", tag, e);
    sb.push_back(it);
  endtask

  task automatic exp_n(input int e, input logic [2:0] n, input logic b, input string tag);
    push(e, K_NRST, {3'b000, n}, {tag, "_nrst"});
    push(e, K_BUSY, {5'b00000, b}, {tag, "_busy"});
  endtask

  // One clock edge, then retire every scoreboard entry due at this edge.
  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    idx = 0;
    while (idx < sb.size()) begin
      if (sb[idx].e <= cyc) begin
        check(sb[idx].tag, observe(sb[idx].kind), sb[idx].val);
        sb.delete(idx);
      end else begin
        idx++;
      end
    end
  endtask

  task automatic run_to(input int e);
    while (cyc < e) tick();
  endtask

  initial begin
    #1 async_rst_i = 1'b1;
    #1;
    check("rst_nrst", {3'b000, nrst_o}, 6'b000000);
    check("rst_state", state_o, 6'b000000);
    check("rst_busy", {5'b00000, busy_o}, 6'b000001);
    check("rst_nrst_b", {5'b00000, nrst_b}, 6'b000000);
    tick();
    tick();

    // Power-up release order.
    async_rst_i = 1'b0;
    ch_en_i     = 3'b111;
    ch_en_b     = 1'b1;
    base        = cyc;
    push(base + 3, K_STATE, 6'b000000, "up_off");
    push(base + 4, K_STATE, 6'b010101, "up_hold");
    exp_n(base + 19, 3'b000, 1'b1, "up");
    exp_n(base + 20, 3'b001, 1'b1, "up");
    exp_n(base + 24, 3'b001, 1'b1, "up");
    exp_n(base + 25, 3'b011, 1'b1, "up");
    exp_n(base + 29, 3'b011, 1'b1, "up");
    exp_n(base + 30, 3'b111, 1'b0, "up");
    push(base + 30, K_STATE, 6'b111111, "up_run");
    push(base + 5, K_NRSTB, 6'b000000, "small_hold");
    push(base + 6, K_NRSTB, 6'b000001, "small_rel");
    run_to(base + 35);

    // Disable channel 1, ripple into channel 2, then re-enable.
    base    = cyc;
    ch_en_i = 3'b101;
    exp_n(base + 3, 3'b111, 1'b0, "dis");
    exp_n(base + 4, 3'b101, 1'b1, "dis");
    push(base + 4, K_STATE, 6'b110011, "dis_off");
    exp_n(base + 5, 3'b001, 1'b1, "dis");
    push(base + 5, K_STATE, 6'b100011, "dis_wait");
    run_to(base + 10);
    base    = cyc;
    ch_en_i = 3'b111;
    exp_n(base + 20, 3'b001, 1'b1, "reen");
    exp_n(base + 21, 3'b011, 1'b1, "reen");
    exp_n(base + 25, 3'b011, 1'b1, "reen");
    exp_n(base + 26, 3'b111, 1'b0, "reen");
    run_to(base + 30);

    // Config change on channel 0 restarts the whole chain.
    base  = cyc;
    cfg_i = 6'b000010;
    exp_n(base + 2, 3'b111, 1'b0, "cfg");
    exp_n(base + 3, 3'b110, 1'b1, "cfg");
    push(base + 3, K_STATE, 6'b111101, "cfg_hold");
    exp_n(base + 4, 3'b100, 1'b1, "cfg");
    exp_n(base + 5, 3'b000, 1'b1, "cfg");
    exp_n(base + 18, 3'b000, 1'b1, "cfg");
    exp_n(base + 19, 3'b001, 1'b1, "cfg");
    exp_n(base + 23, 3'b001, 1'b1, "cfg");
    exp_n(base + 24, 3'b011, 1'b1, "cfg");
    exp_n(base + 28, 3'b011, 1'b1, "cfg");
    exp_n(base + 29, 3'b111, 1'b0, "cfg");
    run_to(base + 33);

    // Soft reset pulse on channel 2 for 10 cycles.
    base        = cyc;
    force_rst_i = 3'b100;
    exp_n(base + 1, 3'b011, 1'b1, "force");
    exp_n(base + 10, 3'b011, 1'b1, "force");
    run_to(base + 10);
    force_rst_i = 3'b000;
    exp_n(base + 16, 3'b011, 1'b1, "force");
    exp_n(base + 26, 3'b011, 1'b1, "force");
    exp_n(base + 27, 3'b111, 1'b0, "force");
    run_to(base + 30);

    // Asynchronous reset in the middle of a hold.
    base  = cyc;
    cfg_i = 6'b000000;
    exp_n(base + 2, 3'b111, 1'b0, "mid");
    exp_n(base + 3, 3'b110, 1'b1, "mid");
    exp_n(base + 8, 3'b000, 1'b1, "mid");
    run_to(base + 8);
    async_rst_i = 1'b1;
    #1;
    check("arst_nrst", {3'b000, nrst_o}, 6'b000000);
    check("arst_state", state_o, 6'b000000);
    check("arst_busy", {5'b00000, busy_o}, 6'b000001);
    check("arst_nrst_b", {5'b00000, nrst_b}, 6'b000000);
    #2;
    async_rst_i = 1'b0;
    base        = cyc;
    push(base + 4, K_STATE, 6'b010101, "re_hold");
    exp_n(base + 19, 3'b000, 1'b1, "re");
    exp_n(base + 20, 3'b001, 1'b1, "re");
    exp_n(base + 24, 3'b001, 1'b1, "re");
    exp_n(base + 25, 3'b011, 1'b1, "re");
    exp_n(base + 30, 3'b111, 1'b0, "re");
    push(base + 5, K_NRSTB, 6'b000000, "re_small_hold");
    push(base + 6, K_NRSTB, 6'b000001, "re_small_rel");
    run_to(base + 33);

    check("sb_drained", 6'(sb.size()), 6'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
